ram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, fixed-latency RAM between the core's instruction-fetch and data (load/store) interfaces. It sits between `riscv_core` and a single-ported `ram`. It issues at most one RAM access per cycle and routes each one-cycle-late response back to the requester that was granted. It replaces the dual-ported memory arrangement so the core can run against single-port SRAM macros.

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter_arb_pick2.sv | 37 +++
 rtl/ram_arbiter.sv | 93 +++++++++
 tb/tb_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types and constants for the single-port RAM arbiter.
//   owner_e     : which requester owns the response arriving next cycle
//   BE_ALL      : byte enables used for every instruction fetch
//   MEM_LATENCY : RAM read latency in cycles (the arbiter is built for 1)
//   IDX_INSTR / IDX_DATA : bit positions inside the two-bit request/grant vectors
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [3:0] BE_ALL      = 4'hF;
  localparam int         MEM_LATENCY = 1;

  localparam int IDX_INSTR = 0;
  localparam int IDX_DATA  = 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the fetch port, the load/store port and the RAM port of the arbiter.
//   slave  : arbiter view (takes requests and RAM read data, drives grants,
//            responses and the RAM access)
//   master : environment view (core requesters plus the RAM itself)
// Parameters: ADDR_WIDTH (byte address), MEM_ADDR_WIDTH (RAM word address).
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH     = 22,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH - 2
);
  logic                      instr_req_i;
  logic [ADDR_WIDTH-1:0]     instr_addr_i;
  logic                      instr_gnt_o;
  logic                      instr_rvalid_o;
  logic [31:0]               instr_rdata_o;

  logic                      data_req_i;
  logic [ADDR_WIDTH-1:0]     data_addr_i;
  logic                      data_we_i;
  logic [3:0]                data_be_i;
  logic [31:0]               data_wdata_i;
  logic                      data_gnt_o;
  logic                      data_rvalid_o;
  logic [31:0]               data_rdata_o;

  logic                      mem_req_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic                      mem_we_o;
  logic [3:0]                mem_be_o;
  logic [31:0]               mem_wdata_o;
  logic [31:0]               mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/ram_arbiter_arb_pick2.sv
// arb_pick2
// Two-input picker returning a one-hot (or zero) grant.
//   i_req[1:0]  : requests, bit IDX_DATA = load/store, bit IDX_INSTR = fetch
//   i_last_data : only with ARB_ROUND_ROBIN_EN; 1 when data won the previous tie
//   o_gnt[1:0]  : grant, same bit layout as i_req
// Macro ARB_ROUND_ROBIN_EN: defined -> alternate on ties; undefined -> data
// always wins a tie. A lone requester always wins.
import ram_arbiter_pkg::*;

module arb_pick2 (
  input  logic [1:0] i_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       i_last_data,
`endif
  output logic [1:0] o_gnt
);

  logic w_data_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
  // The side that lost the previous tie wins this one.
  assign w_data_wins_tie = ~i_last_data;
`else
  assign w_data_wins_tie = 1'b1;
`endif

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[IDX_DATA] && i_req[IDX_INSTR]) begin
      if (w_data_wins_tie) o_gnt[IDX_DATA]  = 1'b1;
      else                 o_gnt[IDX_INSTR] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port, 1-cycle-latency RAM between the fetch and the
// load/store requesters. At most one access per cycle; grants are
// combinational, responses come back one cycle after the grant to whichever
// requester owned that access.
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : ram_arbiter_if.slave (fetch port, data port, RAM port)
// Macro ARB_ROUND_ROBIN_EN: round-robin tie breaking (default: data first).
import ram_arbiter_pkg::*;

module ram_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH - 2
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  ram_arbiter_if.slave  bus
);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  owner_e     r_owner;

  assign w_req[IDX_INSTR] = bus.instr_req_i;
  assign w_req[IDX_DATA]  = bus.data_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_data;

  arb_pick2 u_pick (
    .i_req       (w_req),
    .i_last_data (r_last_data),
    .o_gnt       (w_gnt)
  );

  // Only ties move the pointer; a lone requester does not affect fairness.
  // Reset value 0 means "instr won last", so data takes the first tie.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_data <= 1'b0;
    end else if (&w_req) begin
      r_last_data <= w_gnt[IDX_DATA];
    end
  end
`else
  arb_pick2 u_pick (
    .i_req (w_req),
    .o_gnt (w_gnt)
  );
`endif

  assign bus.instr_gnt_o = w_gnt[IDX_INSTR];
  assign bus.data_gnt_o  = w_gnt[IDX_DATA];
  assign bus.mem_req_o   = |w_gnt;

  // RAM port mux. With no winner the fetch payload is presented, which keeps
  // mem_we_o low while idle.
  always_comb begin
    if (w_gnt[IDX_DATA]) begin
      bus.mem_addr_o  = bus.data_addr_i[ADDR_WIDTH-1:2];
      bus.mem_we_o    = bus.data_we_i;
      bus.mem_be_o    = bus.data_be_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end else begin
      bus.mem_addr_o  = bus.instr_addr_i[ADDR_WIDTH-1:2];
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = BE_ALL;
      bus.mem_wdata_o = '0;
    end
  end

  // Owner of the response that the RAM returns next cycle. The async clear
  // drops any in-flight response the moment reset is asserted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_owner <= OWN_NONE;
    end else if (w_gnt[IDX_DATA]) begin
      r_owner <= OWN_DATA;
    end else if (w_gnt[IDX_INSTR]) begin
      r_owner <= OWN_INSTR;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  assign bus.instr_rvalid_o = (r_owner == OWN_INSTR);
  assign bus.data_rvalid_o  = (r_owner == OWN_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a single-port RAM attached. A
// transaction-level model (winner per rules, pending response, shadow memory)
// is checked against the DUT on every falling edge, and a few literal
// expectations pin down the model. Honours ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW  = 22;
  localparam int MAW = AW - 2;

  logic clk;
  logic rstn;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) u_dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM attached to the DUT ----------------
  logic [31:0] ram [0:1023];
  logic [31:0] ram_rdata;
  assign bus.mem_rdata_i = ram_rdata;

  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      ram_rdata <= ram[bus.mem_addr_o[9:0]];
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) ram[bus.mem_addr_o[9:0]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end
    end
  end

  // ---------------- Behavioural model ----------------
  // Winner codes: 0 none, 1 fetch, 2 load/store.
  logic [31:0] shadow [0:1023];
  logic        pend_v;
  int          pend_who;
  logic        pend_rd;
  logic [31:0] pend_data;
  byte         last_tie;   // "I" or "D": who won the previous tie

  function automatic int model_winner();
    if (bus.data_req_i && bus.instr_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last_tie == "I") ? 2 : 1;
`else
      return 2;
`endif
    end
    if (bus.data_req_i)  return 2;
    if (bus.instr_req_i) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_v   <= 1'b0;
      pend_who <= 0;
      pend_rd  <= 1'b0;
      last_tie <= "I";
    end else begin
      int w;
      int widx;
      logic [31:0] merged;
      w = model_winner();
      pend_v   <= (w != 0);
      pend_who <= w;
      if (bus.data_req_i && bus.instr_req_i) last_tie <= (w == 2) ? "D" : "I";
      if (w == 1) begin
        widx = int'(bus.instr_addr_i[11:2]);
        pend_rd   <= 1'b1;
        pend_data <= shadow[widx];
      end else if (w == 2) begin
        widx = int'(bus.data_addr_i[11:2]);
        pend_rd   <= !bus.data_we_i;
        pend_data <= shadow[widx];
        if (bus.data_we_i) begin
          merged = shadow[widx];
          for (int b = 0; b < 4; b++)
            if (bus.data_be_i[b]) merged[8*b +: 8] = bus.data_wdata_i[8*b +: 8];
          shadow[widx] <= merged;
        end
      end
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin
    int w;
    w = model_winner();
    chk("instr_gnt", {63'd0, bus.instr_gnt_o}, {63'd0, w == 1});
    chk("data_gnt",  {63'd0, bus.data_gnt_o},  {63'd0, w == 2});
    chk("mem_req",   {63'd0, bus.mem_req_o},   {63'd0, w != 0});
    if (w == 2) begin
      chk("mem_addr_d", {44'd0, bus.mem_addr_o}, {44'd0, bus.data_addr_i >> 2});
      chk("mem_we_d",   {63'd0, bus.mem_we_o},   {63'd0, bus.data_we_i});
      chk("mem_be_d",   {60'd0, bus.mem_be_o},   {60'd0, bus.data_be_i});
      if (bus.data_we_i) chk("mem_wdata", {32'd0, bus.mem_wdata_o}, {32'd0, bus.data_wdata_i});
    end else if (w == 1) begin
      chk("mem_addr_i", {44'd0, bus.mem_addr_o}, {44'd0, bus.instr_addr_i >> 2});
      chk("mem_we_i",   {63'd0, bus.mem_we_o},   64'd0);
      chk("mem_be_i",   {60'd0, bus.mem_be_o},   64'hF);
    end
    chk("instr_rvalid", {63'd0, bus.instr_rvalid_o}, {63'd0, pend_v && pend_who == 1});
    chk("data_rvalid",  {63'd0, bus.data_rvalid_o},  {63'd0, pend_v && pend_who == 2});
    if (pend_v && pend_rd) begin
      chk("instr_rdata", {32'd0, bus.instr_rdata_o}, {32'd0, pend_data});
      chk("data_rdata",  {32'd0, bus.data_rdata_o},  {32'd0, pend_data});
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.instr_req_i  = 1'b0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
  endtask

  string seq;
  string exp_seq;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = i * 32'h9E3779B1;
      shadow[i] = i * 32'h9E3779B1;
    end
    ram[32'h20] = 32'h0000_0013;  shadow[32'h20] = 32'h0000_0013;
    ram[32'h40] = 32'h1234_5678;  shadow[32'h40] = 32'h1234_5678;
    ram_rdata = '0;

    // Reset held with both requesters active.
    rstn             = 1'b0;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 22'h80;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 22'h100;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'hF;
    bus.data_wdata_i = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_instr_rvalid", {63'd0, bus.instr_rvalid_o}, 64'd0);
      chk("rst_data_rvalid",  {63'd0, bus.data_rvalid_o},  64'd0);
    end

    // First cycle after release: data wins the tie in either configuration.
    step();
    rstn = 1'b1;
    @(negedge clk);
    $display("txn reset-release tie: data_gnt=%0b instr_gnt=%0b", bus.data_gnt_o, bus.instr_gnt_o);
    chk("post_rst_data_gnt",  {63'd0, bus.data_gnt_o},  64'd1);
    chk("post_rst_instr_gnt", {63'd0, bus.instr_gnt_o}, 64'd0);
    step();
    idle_reqs();
    @(negedge clk);
    chk("post_rst_load_rdata", {32'd0, bus.data_rdata_o}, 64'h1234_5678);

    // Fetch only.
    step();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 22'h80;
    @(negedge clk);
    chk("fetch_gnt",      {63'd0, bus.instr_gnt_o}, 64'd1);
    chk("fetch_mem_addr", {44'd0, bus.mem_addr_o},  64'h20);
    step();
    idle_reqs();
    @(negedge clk);
    $display("txn fetch 0x80: rvalid=%0b rdata=0x%08h", bus.instr_rvalid_o, bus.instr_rdata_o);
    chk("fetch_rvalid",      {63'd0, bus.instr_rvalid_o}, 64'd1);
    chk("fetch_rdata",       {32'd0, bus.instr_rdata_o},  64'h13);
    chk("fetch_data_rvalid", {63'd0, bus.data_rvalid_o},  64'd0);

    // Store then back-to-back load of the same word.
    step();
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 22'h100;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b0011;
    bus.data_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("store_mem_we", {63'd0, bus.mem_we_o}, 64'd1);
    step();
    bus.data_we_i = 1'b0;
    bus.data_be_i = 4'hF;
    @(negedge clk);
    $display("txn store 0x100 be=0011: rvalid=%0b", bus.data_rvalid_o);
    chk("store_rvalid", {63'd0, bus.data_rvalid_o}, 64'd1);
    step();
    idle_reqs();
    @(negedge clk);
    $display("txn load 0x100: rvalid=%0b rdata=0x%08h", bus.data_rvalid_o, bus.data_rdata_o);
    chk("load_rvalid", {63'd0, bus.data_rvalid_o}, 64'd1);
    chk("load_rdata",  {32'd0, bus.data_rdata_o},  64'h1234_BEEF);

    // Reset asserted the cycle after a data grant.
    step();
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 22'h104;
    step();
    rstn = 1'b0;
    idle_reqs();
    repeat (2) begin
      @(negedge clk);
      $display("txn reset mid-access: data_rvalid=%0b", bus.data_rvalid_o);
      chk("midrst_data_rvalid", {63'd0, bus.data_rvalid_o}, 64'd0);
    end

    // Continuous tie for 6 cycles, starting right at reset release.
    step();
    rstn             = 1'b1;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 22'h84;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 22'h108;
    seq = "";
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.data_gnt_o)       seq = {seq, "D"};
      else if (bus.instr_gnt_o) seq = {seq, "I"};
      else                      seq = {seq, "-"};
      step();
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = "DIDIDI";
`else
    exp_seq = "DDDDDD";
`endif
    $display("txn tie x6: grants=%s expected=%s", seq, exp_seq);
    total++;
    if (seq != exp_seq) begin
      bad++;
      $display("FAIL tie_sequence actual=%s required=%s", seq, exp_seq);
    end

    idle_reqs();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
